// File: rtl/io_store_buffer.sv
// io_store_buffer: store-side memory-mapped I/O block.
// Decodes CPU stores into the I/O window and merges them into the output registers
// (LEDR, LEDG, HEXL, HEXH, LCD) with byte/half/word lane masking.
// Every accepted LCD write starts an enable strobe sequence: LCD_PULSE cycles high,
// then LCD_HOLD idle cycles. Further LCD stores stall until the sequence ends.
// Optional feature macro: STORE_MISALIGN_TRAP_EN (drop misaligned half/word stores
// and flag them on o_st_misalign instead of forcing them to alignment).
module io_store_buffer #(
  parameter logic [15:0] IO_BASE   = 16'h1000,
  parameter int          LCD_PULSE = 4,
  parameter int          LCD_HOLD  = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_st_en,
  input  logic [31:0] i_st_addr,
  input  logic [31:0] i_st_data,
  input  logic [1:0]  i_st_size,
  input  logic        f_io_valid,
  output logic        o_st_stall,
  output logic        o_st_ack,
  output logic        o_st_misalign,
  output logic [31:0] b_io_ledr,
  output logic [31:0] b_io_ledg,
  output logic [31:0] b_io_hexl,
  output logic [31:0] b_io_hexh,
  output logic [31:0] b_io_lcd,
  output logic        o_lcd_en
);

  localparam int CW = 8;

  typedef enum logic [1:0] {IDLE, PULSE, HOLD} lcd_state_e;

  lcd_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lcd_en_q;
  logic          ack_q;
  logic          misalign_q;
  logic [31:0]   io_q [0:4];

  logic          in_win;
  logic [3:0]    sel;
  logic          is_lcd;
  logic          accept;
  logic          drop;
  logic          wr_go;
  logic          lcd_go;
  logic [3:0]    lane_en;
  logic [31:0]   lane_data;

  // Address bits inside a register page carry no meaning here.
  logic          unused_addr;
  assign unused_addr = ^i_st_addr[11:2];

  assign in_win     = f_io_valid && (i_st_addr[31:16] == IO_BASE);
  assign sel        = i_st_addr[15:12];
  assign is_lcd     = in_win && (sel == 4'd4);
  assign o_st_stall = i_st_en && is_lcd && (state_q != IDLE);
  assign accept     = i_st_en && !o_st_stall;

`ifdef STORE_MISALIGN_TRAP_EN
  assign drop = ((i_st_size == 2'b01) && i_st_addr[0]) ||
                (i_st_size[1] && (i_st_addr[1:0] != 2'b00));
`else
  // Misaligned half/word stores are forced to alignment: the lane mask below
  // simply ignores the low address bits for those sizes.
  assign drop = 1'b0;
`endif

  assign wr_go  = accept && in_win && !drop;
  assign lcd_go = accept && is_lcd && !drop;

  // Lane enables and lane-replicated write data for the store size.
  always_comb begin
    lane_en   = 4'b1111;
    lane_data = i_st_data;
    case (i_st_size)
      2'b00: begin
        lane_en   = 4'b0001 << i_st_addr[1:0];
        lane_data = {4{i_st_data[7:0]}};
      end
      2'b01: begin
        lane_en   = i_st_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{i_st_data[15:0]}};
      end
      default: begin
        lane_en   = 4'b1111;
        lane_data = i_st_data;
      end
    endcase
  end

  // Output registers: masked byte-lane merge into the selected register.
  always_ff @(posedge i_clk) begin
    for (int r = 0; r < 5; r++) begin
      if (!i_reset) begin
        io_q[r] <= '0;
      end else if (wr_go && (sel == 4'(r))) begin
        for (int l = 0; l < 4; l++) begin
          if (lane_en[l]) io_q[r][8*l +: 8] <= lane_data[8*l +: 8];
        end
      end
    end
  end

  // LCD strobe sequencer: next state and counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (lcd_go) begin
          state_d = PULSE;
          cnt_d   = CW'(LCD_PULSE - 1);
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          if (LCD_HOLD == 0) begin
            state_d = IDLE;
          end else begin
            state_d = HOLD;
            cnt_d   = CW'(LCD_HOLD - 1);
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state, registered strobe and the one-cycle handshake pulses.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lcd_en_q   <= 1'b0;
      ack_q      <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lcd_en_q   <= (state_d == PULSE);
      ack_q      <= accept;
      misalign_q <= accept && drop;
    end
  end

  assign o_st_ack  = ack_q;
  assign o_lcd_en  = lcd_en_q;
  assign b_io_ledr = io_q[0];
  assign b_io_ledg = io_q[1];
  assign b_io_hexl = io_q[2];
  assign b_io_hexh = io_q[3];
  assign b_io_lcd  = io_q[4];

`ifdef STORE_MISALIGN_TRAP_EN
  assign o_st_misalign = misalign_q;
`else
  assign o_st_misalign = 1'b0;
  logic unused_misalign;
  assign unused_misalign = misalign_q;
`endif

endmodule
